// File: rtl/bitwise_logic_iter.sv
// bitwise_logic_iter
// Multi-cycle bitwise logic unit. Applies AND, OR, XOR or NOR to two
// WIDTH-bit operands, CHUNK bits per clock, lowest slice first. A start
// pulse latches the operands and the operation. busy stays high while the
// slices are worked through. done pulses for one cycle when the registered
// result and the zero flag have just been updated.
//
// Ports:
//   clock    in   1      rising-edge clock
//   reset    in   1      synchronous, active-low reset
//   start    in   1      request a new operation (only looked at while idle)
//   op       in   2      00 AND, 01 OR, 10 XOR, 11 NOR
//   input_a  in   WIDTH  operand A
//   input_b  in   WIDTH  operand B
//   busy     out  1      high while an operation is running
//   done     out  1      one-cycle pulse: out/zero were just updated
//   out      out  WIDTH  result of the last completed operation
//   zero     out  1      out == 0
module bitwise_logic_iter #(
   parameter int WIDTH = 32,
   parameter int CHUNK = 8
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] input_a,
   input  logic [WIDTH-1:0] input_b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] out,
   output logic             zero
);

   localparam int NCHUNK = WIDTH / CHUNK;
   localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
   localparam logic [CW-1:0] LAST = CW'(NCHUNK - 1);

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   state_t           state;
   logic [CW-1:0]    count;
   logic [WIDTH-1:0] a_lat;
   logic [WIDTH-1:0] b_lat;
   logic [1:0]       op_lat;
   logic [WIDTH-1:0] scratch;
   logic [WIDTH-1:0] scratch_next;
   logic [CHUNK-1:0] slice_a;
   logic [CHUNK-1:0] slice_b;
   logic [CHUNK-1:0] slice_r;

   // Pick the operand slice addressed by count. Written as a mux over
   // constant slice positions so only CHUNK bits of logic do the real work.
   always_comb begin
      slice_a = '0;
      slice_b = '0;
      for (int i = 0; i < NCHUNK; i++) begin
         if (count == CW'(i)) begin
            slice_a = a_lat[i*CHUNK +: CHUNK];
            slice_b = b_lat[i*CHUNK +: CHUNK];
         end
      end
   end

   // The one CHUNK-wide logic unit shared by every slice.
   always_comb begin
      case (op_lat)
         2'b00:   slice_r = slice_a & slice_b;
         2'b01:   slice_r = slice_a | slice_b;
         2'b10:   slice_r = slice_a ^ slice_b;
         default: slice_r = ~(slice_a | slice_b);
      endcase
   end

   // Merge the freshly computed slice into the scratch result. On the last
   // slice this value is what gets published to out in the same edge.
   always_comb begin
      scratch_next = scratch;
      for (int i = 0; i < NCHUNK; i++) begin
         if (count == CW'(i)) begin
            scratch_next[i*CHUNK +: CHUNK] = slice_r;
         end
      end
   end

   // Control FSM and all registered outputs. out and zero move only on
   // completion or reset, so partial results never leak out. done defaults
   // low every cycle so it can only ever be a single-cycle pulse.
   always_ff @(posedge clock) begin
      if (!reset) begin
         state   <= IDLE;
         busy    <= 1'b0;
         done    <= 1'b0;
         out     <= '0;
         zero    <= 1'b1;
         count   <= '0;
         a_lat   <= '0;
         b_lat   <= '0;
         op_lat  <= 2'b00;
         scratch <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  a_lat   <= input_a;
                  b_lat   <= input_b;
                  op_lat  <= op;
                  scratch <= '0;
                  count   <= '0;
                  busy    <= 1'b1;
                  state   <= RUN;
               end
            end
            RUN: begin
               scratch <= scratch_next;
               if (count == LAST) begin
                  out   <= scratch_next;
                  zero  <= (scratch_next == '0);
                  done  <= 1'b1;
                  busy  <= 1'b0;
                  count <= '0;
                  state <= IDLE;
               end else begin
                  count <= count + 1'b1;
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_bitwise_logic_iter.sv
// tb_bitwise_logic_iter
// Directed bench for bitwise_logic_iter. Three copies share the same
// stimulus: CHUNK=8 (main target), CHUNK=32 and CHUNK=1 (latency extremes).
module tb_bitwise_logic_iter;

   logic        clock;
   logic        reset;
   logic        start;
   logic [1:0]  op;
   logic [31:0] input_a;
   logic [31:0] input_b;

   logic        d8_busy,  d32_busy,  d1_busy;
   logic        d8_done,  d32_done,  d1_done;
   logic [31:0] d8_out,   d32_out,   d1_out;
   logic        d8_zero,  d32_zero,  d1_zero;

   int total;
   int bad;

   bitwise_logic_iter #(.WIDTH(32), .CHUNK(8)) dut8 (
      .clock(clock), .reset(reset), .start(start), .op(op),
      .input_a(input_a), .input_b(input_b),
      .busy(d8_busy), .done(d8_done), .out(d8_out), .zero(d8_zero)
   );

   bitwise_logic_iter #(.WIDTH(32), .CHUNK(32)) dut32 (
      .clock(clock), .reset(reset), .start(start), .op(op),
      .input_a(input_a), .input_b(input_b),
      .busy(d32_busy), .done(d32_done), .out(d32_out), .zero(d32_zero)
   );

   bitwise_logic_iter #(.WIDTH(32), .CHUNK(1)) dut1 (
      .clock(clock), .reset(reset), .start(start), .op(op),
      .input_a(input_a), .input_b(input_b),
      .busy(d1_busy), .done(d1_done), .out(d1_out), .zero(d1_zero)
   );

   // Free-running 10-unit clock.
   always #5 clock = ~clock;

   // Advance past the next rising edge; outputs are stable 1 unit later.
   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   // Present an operation with start high for exactly one edge (E0).
   task automatic start_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
      op      = o;
      input_a = a;
      input_b = b;
      start   = 1'b1;
      tick();
      start   = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b0;
      start = 1'b0;
      tick();
      tick();
      total++;
      if (d8_busy !== 1'b0) begin bad++; $display("[TB] FAIL reset_busy: got %b expected 0", d8_busy); end
      total++;
      if (d8_done !== 1'b0) begin bad++; $display("[TB] FAIL reset_done: got %b expected 0", d8_done); end
      total++;
      if (d8_out !== 32'h0) begin bad++; $display("[TB] FAIL reset_out: got %h expected 00000000", d8_out); end
      total++;
      if (d8_zero !== 1'b1) begin bad++; $display("[TB] FAIL reset_zero: got %b expected 1", d8_zero); end
      reset = 1'b1;
      tick();
   endtask

   // Scenario 1: OR, cycle-by-cycle busy/done/out profile.
   task automatic test_or_timing();
      start_op(2'b01, 32'hF0F00000, 32'h00000F0F);
      for (int k = 0; k < 4; k++) begin
         total++;
         if (d8_busy !== 1'b1 || d8_done !== 1'b0) begin
            bad++;
            $display("[TB] FAIL or_run_%0d: got busy=%b done=%b expected busy=1 done=0", k, d8_busy, d8_done);
         end
         total++;
         if (d8_out !== 32'h0) begin
            bad++;
            $display("[TB] FAIL or_partial_%0d: got out=%h expected 00000000", k, d8_out);
         end
         if (k < 3) tick();
      end
      tick();
      total++;
      if (d8_done !== 1'b1 || d8_busy !== 1'b0) begin
         bad++;
         $display("[TB] FAIL or_done: got busy=%b done=%b expected busy=0 done=1", d8_busy, d8_done);
      end
      total++;
      if (d8_out !== 32'hF0F00F0F || d8_zero !== 1'b0) begin
         bad++;
         $display("[TB] FAIL or_result: got out=%h zero=%b expected F0F00F0F 0", d8_out, d8_zero);
      end
      tick();
      total++;
      if (d8_done !== 1'b0 || d8_out !== 32'hF0F00F0F) begin
         bad++;
         $display("[TB] FAIL or_after: got done=%b out=%h expected 0 F0F00F0F", d8_done, d8_out);
      end
   endtask

   // Scenario 2: remaining operations, including the zero flag both ways.
   task automatic test_ops();
      logic [1:0]  v_op;
      logic [31:0] v_a, v_b, v_out, obs_out;
      logic        v_zero, obs_zero;
      int          lat;
      for (int t = 0; t < 4; t++) begin
         case (t)
            0:       begin v_op = 2'b00; v_a = 32'hAAAAAAAA; v_b = 32'h55555555; v_out = 32'h00000000; v_zero = 1'b1; end
            1:       begin v_op = 2'b10; v_a = 32'hFFFF0000; v_b = 32'h0F0F0F0F; v_out = 32'hF0F00F0F; v_zero = 1'b0; end
            2:       begin v_op = 2'b11; v_a = 32'h00000000; v_b = 32'h00000000; v_out = 32'hFFFFFFFF; v_zero = 1'b0; end
            default: begin v_op = 2'b11; v_a = 32'hF0000001; v_b = 32'h0F00FF00; v_out = 32'h00FF00FE; v_zero = 1'b0; end
         endcase
         start_op(v_op, v_a, v_b);
         lat      = -1;
         obs_out  = 32'hx;
         obs_zero = 1'bx;
         for (int k = 1; k <= 10 && lat < 0; k++) begin
            tick();
            if (d8_done === 1'b1) begin
               lat      = k;
               obs_out  = d8_out;
               obs_zero = d8_zero;
            end
         end
         total++;
         if (lat !== 4) begin bad++; $display("[TB] FAIL ops_latency_%0d: got %0d expected 4", t, lat); end
         total++;
         if (obs_out !== v_out) begin bad++; $display("[TB] FAIL ops_out_%0d: got %h expected %h", t, obs_out, v_out); end
         total++;
         if (obs_zero !== v_zero) begin bad++; $display("[TB] FAIL ops_zero_%0d: got %b expected %b", t, obs_zero, v_zero); end
         tick();
         total++;
         if (d8_done !== 1'b0) begin bad++; $display("[TB] FAIL ops_pulse_%0d: got done=%b expected 0", t, d8_done); end
      end
   endtask

   // Scenario 3: operand change and start during RUN are both ignored.
   task automatic test_run_isolation();
      int          dones;
      int          at;
      logic [31:0] obs_out;
      start_op(2'b01, 32'h00000001, 32'h00000002);
      tick();
      input_a = 32'hFFFFFFFF;
      start   = 1'b1;
      tick();
      start   = 1'b0;
      dones   = 0;
      at      = -1;
      obs_out = 32'hx;
      for (int k = 3; k <= 14; k++) begin
         tick();
         if (d8_done === 1'b1) begin
            dones++;
            if (at < 0) begin at = k; obs_out = d8_out; end
         end
      end
      total++;
      if (dones !== 1) begin bad++; $display("[TB] FAIL iso_pulses: got %0d expected 1", dones); end
      total++;
      if (at !== 4) begin bad++; $display("[TB] FAIL iso_latency: got %0d expected 4", at); end
      total++;
      if (obs_out !== 32'h00000003) begin bad++; $display("[TB] FAIL iso_out: got %h expected 00000003", obs_out); end
   endtask

   // Scenario 4: start accepted in the done cycle; first result held meanwhile.
   task automatic test_back_to_back();
      start_op(2'b01, 32'h00001111, 32'h00002222);
      tick();
      tick();
      tick();
      tick();
      total++;
      if (d8_done !== 1'b1 || d8_out !== 32'h00003333) begin
         bad++;
         $display("[TB] FAIL b2b_first: got done=%b out=%h expected 1 00003333", d8_done, d8_out);
      end
      op      = 2'b00;
      input_a = 32'hFF00FF00;
      input_b = 32'h0FF00FF0;
      start   = 1'b1;
      tick();
      start   = 1'b0;
      total++;
      if (d8_busy !== 1'b1 || d8_done !== 1'b0) begin
         bad++;
         $display("[TB] FAIL b2b_accept: got busy=%b done=%b expected 1 0", d8_busy, d8_done);
      end
      for (int k = 1; k <= 3; k++) begin
         tick();
         total++;
         if (d8_done !== 1'b0 || d8_out !== 32'h00003333) begin
            bad++;
            $display("[TB] FAIL b2b_hold_%0d: got done=%b out=%h expected 0 00003333", k, d8_done, d8_out);
         end
      end
      tick();
      total++;
      if (d8_done !== 1'b1 || d8_out !== 32'h0F000F00 || d8_zero !== 1'b0) begin
         bad++;
         $display("[TB] FAIL b2b_second: got done=%b out=%h zero=%b expected 1 0F000F00 0", d8_done, d8_out, d8_zero);
      end
      tick();
   endtask

   // Scenario 5: reset in the middle of RUN abandons the operation.
   task automatic test_reset_mid_run();
      int dones;
      start_op(2'b01, 32'h12345678, 32'h00000000);
      tick();
      tick();
      tick();
      tick();
      total++;
      if (d8_done !== 1'b1 || d8_out !== 32'h12345678) begin
         bad++;
         $display("[TB] FAIL rst_prior: got done=%b out=%h expected 1 12345678", d8_done, d8_out);
      end
      tick();
      start_op(2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF);
      tick();
      reset = 1'b0;
      tick();
      total++;
      if (d8_busy !== 1'b0 || d8_done !== 1'b0) begin
         bad++;
         $display("[TB] FAIL rst_ctrl: got busy=%b done=%b expected 0 0", d8_busy, d8_done);
      end
      total++;
      if (d8_out !== 32'h0 || d8_zero !== 1'b1) begin
         bad++;
         $display("[TB] FAIL rst_result: got out=%h zero=%b expected 00000000 1", d8_out, d8_zero);
      end
      reset = 1'b1;
      dones = 0;
      for (int k = 0; k < 8; k++) begin
         tick();
         if (d8_done === 1'b1 || d8_busy === 1'b1) dones++;
      end
      total++;
      if (dones !== 0 || d8_out !== 32'h0) begin
         bad++;
         $display("[TB] FAIL rst_quiet: got activity=%0d out=%h expected 0 00000000", dones, d8_out);
      end
   endtask

   // Scenario 6: same OR on the CHUNK=32 and CHUNK=1 copies.
   task automatic test_chunk_sizes();
      int          lat8, lat32, lat1, busy1;
      logic [31:0] o8, o32, o1;
      reset = 1'b0;
      tick();
      reset = 1'b1;
      start_op(2'b01, 32'hF0F00000, 32'h00000F0F);
      lat8 = -1; lat32 = -1; lat1 = -1;
      o8 = 32'hx; o32 = 32'hx; o1 = 32'hx;
      busy1 = (d1_busy === 1'b1) ? 1 : 0;
      for (int k = 1; k <= 40; k++) begin
         tick();
         if (d1_busy === 1'b1) busy1++;
         if (d8_done === 1'b1 && lat8 < 0) begin lat8 = k; o8 = d8_out; end
         if (d32_done === 1'b1 && lat32 < 0) begin lat32 = k; o32 = d32_out; end
         if (d1_done === 1'b1 && lat1 < 0) begin lat1 = k; o1 = d1_out; end
      end
      total++;
      if (lat32 !== 1) begin bad++; $display("[TB] FAIL c32_latency: got %0d expected 1", lat32); end
      total++;
      if (o32 !== 32'hF0F00F0F) begin bad++; $display("[TB] FAIL c32_out: got %h expected F0F00F0F", o32); end
      total++;
      if (lat1 !== 32) begin bad++; $display("[TB] FAIL c1_latency: got %0d expected 32", lat1); end
      total++;
      if (o1 !== 32'hF0F00F0F) begin bad++; $display("[TB] FAIL c1_out: got %h expected F0F00F0F", o1); end
      total++;
      if (busy1 !== 32) begin bad++; $display("[TB] FAIL c1_busy_cycles: got %0d expected 32", busy1); end
      total++;
      if (lat8 !== 4 || o8 !== 32'hF0F00F0F) begin
         bad++;
         $display("[TB] FAIL c8_check: got lat=%0d out=%h expected 4 F0F00F0F", lat8, o8);
      end
   endtask

   // Run every scenario in order, then report.
   initial begin
      clock   = 1'b0;
      reset   = 1'b0;
      start   = 1'b0;
      op      = 2'b00;
      input_a = 32'h0;
      input_b = 32'h0;
      total   = 0;
      bad     = 0;
      test_reset();
      test_or_timing();
      test_ops();
      test_run_isolation();
      test_back_to_back();
      test_reset_mid_run();
      test_chunk_sizes();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/bitwise_logic_iter.md
Name: bitwise_logic_iter

Overview:
Parametrised, multi-cycle bitwise logic unit for the arithmetic elements group. It generalises the single-function combinational OR element to WIDTH bits and four selectable operations: AND, OR, XOR and NOR. It evaluates CHUNK bits per clock under a start/busy/done handshake, which lets wide datapaths trade latency for area. Results and a zero flag are registered and held until the next operation completes.

Parameters:
WIDTH, 32, operand and result width in bits; must be a multiple of CHUNK.
CHUNK, 8, bits evaluated per RUN cycle; 1 <= CHUNK <= WIDTH.
Derived constant NCHUNK = WIDTH/CHUNK. The counter width is clog2(NCHUNK), minimum 1.

Ports:
clock    in   1      system clock; all state updates on the rising edge
reset    in   1      synchronous, active-low reset
start    in   1      request a new operation; sampled only in IDLE
op       in   2      operation select: 00 AND, 01 OR, 10 XOR, 11 NOR
input_a  in   WIDTH  operand A
input_b  in   WIDTH  operand B
busy     out  1      high while an operation is in progress (state RUN)
done     out  1      single-cycle pulse: out/zero were just updated
out      out  WIDTH  registered result of the last completed operation
zero     out  1      registered flag: out == 0

Interface decision: reset is named reset and is synchronous, active-low. The clock is named clock.

Behaviour:
- Reset (reset==0 at a rising edge):
  - state=IDLE, busy=0, done=0, out=0, zero=1, count=0.
  - Reset overrides every other input.
- States: IDLE and RUN. busy is registered and equals (state==RUN).
- IDLE:
  - start==1 at an edge: latch input_a, input_b and op into internal registers, clear the scratch result, count=0, go to RUN.
  - start==0: remain in IDLE.
- RUN:
  - Each edge computes slice [count*CHUNK +: CHUNK] of op(A_lat, B_lat) into the scratch result, then increments count.
  - Slices are processed LSB slice first.
  - When the slice with count==NCHUNK-1 is processed, on that same edge:
    - out <= the full scratch result, including this final slice;
    - zero <= (that value == 0);
    - done <= 1;
    - state <= IDLE.
- Latency: start is sampled at edge E0. done is high and out is valid in the cycle following edge E0+NCHUNK. busy is high for exactly NCHUNK cycles. With CHUNK==WIDTH, latency is 1.
- done is high for exactly one cycle and is low in every other cycle.
- out and zero change only on completion or reset. Partial results are never visible on out.
- Operands are latched at start. Changes to input_a, input_b or op during RUN have no effect.
- start during RUN is ignored. It is not queued.
- Back-to-back operation: start may be high in the cycle where done==1 (state already IDLE). It is accepted, so the next done arrives NCHUNK cycles later.
- Reset mid-RUN: the operation is abandoned, no done is produced, and out is cleared to 0.
- NOR is ~(A|B), computed per slice over the full WIDTH. No bits outside WIDTH exist.

Test Plan:
1. OR, WIDTH=32, CHUNK=8: a=0xF0F00000, b=0x00000F0F, start for 1 cycle -> busy high for 4 cycles; then done=1 for 1 cycle, out=0xF0F00F0F, zero=0.
2. AND: a=0xAAAAAAAA, b=0x55555555 -> out=0x00000000, zero=1. XOR: a=0xFFFF0000, b=0x0F0F0F0F -> out=0xF0F00F0F. NOR: a=0, b=0 -> out=0xFFFFFFFF, zero=0.
3. Start an OR of 0x1/0x2, then in RUN cycle 2 change a to 0xFFFFFFFF and pulse start -> out=0x00000003, exactly one done pulse.
4. Assert start with a new op in the done cycle -> second done exactly 4 cycles later with the correct result. out holds the first result until then.
5. Drive reset low in RUN cycle 2 after a prior result of 0x12345678 -> next cycle: busy=0, done=0, out=0, zero=1. No done follows.
6. Re-elaborate with CHUNK=32 and CHUNK=1 and repeat scenario 1 -> done after 1 cycle and after 32 cycles respectively, same out value.
